// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - RV32I pipeline buffer types and MEM-stage encodings
package mem_access_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_fsm_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] wb_sel;
        logic [2:0] funct3;
    } ctrl_word_t;

    typedef struct packed {
        ctrl_word_t  ctrl_wd;
        logic [31:0] alu_out;
        logic [31:0] mar;
        logic [31:0] mem_data_out;
        logic        cmp_out;
        logic [31:0] u_imm;
        logic [4:0]  rd;
    } EX_MEM_stage_t;

    typedef struct packed {
        ctrl_word_t  ctrl_wd;
        logic [31:0] alu_out;
        logic [31:0] u_imm;
        logic [4:0]  rd;
        logic        cmp_out;
        logic [31:0] mdr;
        logic        valid;
    } MEM_WB_stage_t;

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/response bus
interface mem_access_if #(
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
);
    logic              read;
    logic              write;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] rdata;
    logic              resp;

    modport master (output read, write, address, wdata, wmask, input rdata, resp);
    modport slave  (input read, write, address, wdata, wmask, output rdata, resp);
endinterface

// File: rtl/mem_access_load_extend.sv
// rtl/mem_access_load_extend.sv - byte-lane alignment and sign/zero extension of load data
module load_extend
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] mdr
);
    // Only the low half-word survives the shift; misaligned halves zero-fill above the last byte.
    logic [15:0] low;

    assign low = 16'(rdata >> {offset, 3'b000});

    always_comb begin
        mdr = rdata;
        case (load_funct3_t'(funct3))
            LB:      mdr = {{(DATA_W-8){low[7]}}, low[7:0]};
            LBU:     mdr = {{(DATA_W-8){1'b0}}, low[7:0]};
            LH:      mdr = {{(DATA_W-16){low[15]}}, low};
            LHU:     mdr = {{(DATA_W-16){1'b0}}, low};
            default: mdr = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: data-memory handshake, stall generation, MEM/WB payload
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  EX_MEM_stage_t ex_mem_in,
    input  logic          ex_mem_valid,
    input  logic          pipe_advance,
    output MEM_WB_stage_t mem_wb_out,
    output logic          mem_stall,
    mem_access_if.master  dmem
);
    mem_fsm_t          state, state_next;
    logic [DATA_W-1:0] rdata_hold;
    logic [DATA_W-1:0] load_src;
    logic [DATA_W-1:0] mdr;
    logic [MASK_W-1:0] store_mask;
    logic              mem_op;
    logic              req_active;

    assign mem_op     = ex_mem_valid & (ex_mem_in.ctrl_wd.mem_read | ex_mem_in.ctrl_wd.mem_write);
    assign req_active = rst & mem_op & (state != DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rdata_hold <= '0;
        end else begin
            state <= state_next;
            if (dmem.resp) begin
                rdata_hold <= dmem.rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (dmem.resp) begin
                        state_next = pipe_advance ? IDLE : DONE;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // A flushed instruction abandons its request rather than waiting forever.
                if (!mem_op) begin
                    state_next = IDLE;
                end else if (dmem.resp) begin
                    state_next = pipe_advance ? IDLE : DONE;
                end
            end
            DONE: begin
                if (pipe_advance) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        store_mask = '1;
        if (ex_mem_in.ctrl_wd.mem_write) begin
            case (store_funct3_t'(ex_mem_in.ctrl_wd.funct3))
                SB:      store_mask = MASK_W'(1) << ex_mem_in.mar[1:0];
                SH:      store_mask = MASK_W'(3) << ex_mem_in.mar[1:0];
                default: store_mask = '1;
            endcase
        end
    end

    assign dmem.read    = req_active & ex_mem_in.ctrl_wd.mem_read;
    assign dmem.write   = req_active & ex_mem_in.ctrl_wd.mem_write;
    assign dmem.address = {ex_mem_in.mar[DATA_W-1:2], 2'b00};
    assign dmem.wdata   = ex_mem_in.mem_data_out;
    assign dmem.wmask   = store_mask;

    // Kept free of pipe_advance: the hazard unit derives pipe_advance from this stall.
    assign mem_stall = req_active & ~dmem.resp;

    assign load_src = dmem.resp ? dmem.rdata : rdata_hold;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata  (load_src),
        .offset (ex_mem_in.mar[1:0]),
        .funct3 (ex_mem_in.ctrl_wd.funct3),
        .mdr    (mdr)
    );

    always_comb begin
        mem_wb_out.ctrl_wd = ex_mem_in.ctrl_wd;
        mem_wb_out.alu_out = ex_mem_in.alu_out;
        mem_wb_out.u_imm   = ex_mem_in.u_imm;
        mem_wb_out.rd      = ex_mem_in.rd;
        mem_wb_out.cmp_out = ex_mem_in.cmp_out;
        mem_wb_out.mdr     = mdr;
        mem_wb_out.valid   = ex_mem_valid & ~mem_stall;
    end
endmodule
